// File: rtl/sensor_pkg.sv
// Shared constants, state encoding and frame byte table for the IMU command path.
package sensor_pkg;

  localparam logic [7:0]  HDR0       = 8'hFF;
  localparam logic [7:0]  HDR1       = 8'hAA;
  localparam logic [7:0]  REG_UNLOCK = 8'h69;
  localparam logic [15:0] UNLOCK_KEY = 16'hB588;
  localparam logic [7:0]  REG_SAVE   = 8'h00;

  localparam logic [2:0] LAST_BYTE  = 3'd4;
  localparam logic [1:0] LAST_FRAME = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  // Every frame is HDR0 HDR1 <reg> <val lo> <val hi>; only reg/val differ per frame.
  function automatic logic [7:0] frame_byte(input logic [1:0]  frame,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  addr,
                                            input logic [15:0] data);
    logic [7:0]  reg_sel;
    logic [15:0] val;
    logic [7:0]  result;
    reg_sel = REG_SAVE;
    val     = 16'h0000;
    case (frame)
      2'd0:    begin reg_sel = REG_UNLOCK; val = UNLOCK_KEY; end
      2'd1:    begin reg_sel = addr;       val = data;       end
      default: ;
    endcase
    case (idx)
      3'd0:    result = HDR0;
      3'd1:    result = HDR1;
      3'd2:    result = reg_sel;
      3'd3:    result = val[7:0];
      3'd4:    result = val[15:8];
      default: result = HDR0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; ready rises in the last stop-bit cycle so bytes can chain.
module uart_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk_uart,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'd8;
  localparam logic [3:0]    STOP_BIT  = 4'd9;

  logic          active_q, active_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          last_cycle;

  assign last_cycle = active_q && (bit_q == STOP_BIT) && (cnt_q == CNT_LAST);
  assign ready      = !active_q || last_cycle;
  assign tx         = tx_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    active_d = active_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (valid && ready) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      cnt_d    = '0;
      shift_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (bit_q == STOP_BIT) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_DATA) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/imu_config.sv
// IMU register-write sequencer: sends unlock, write and save frames over the radio UART.
module imu_config
  import sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int GAP_CYCLES   = 2304
) (
  input  logic        clk_uart,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] reg_data,
  output logic        busy,
  output logic        done,
  output logic        wireless_rx
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  frame_q, frame_d;
  logic [2:0]  byte_q, byte_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic [1:0]  sel_frame;
  logic [2:0]  sel_byte;

  assign tx_data = frame_byte(sel_frame, sel_byte, addr_q, data_q);
  assign busy    = busy_q;
  assign done    = done_q;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_uart (clk_uart),
    .rst      (rst),
    .data     (tx_data),
    .valid    (tx_valid),
    .ready    (tx_ready),
    .tx       (wireless_rx)
  );

  // In SEND the transmitter is always mid-byte, so tx_ready marks the end of a stop bit.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    byte_d    = byte_q;
    gap_d     = gap_q;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_valid  = 1'b0;
    sel_frame = frame_q;
    sel_byte  = byte_q;
    case (state_q)
      ST_IDLE: begin
        sel_frame = 2'd0;
        sel_byte  = 3'd0;
        if (start) begin
          tx_valid = 1'b1;
          state_d  = ST_SEND;
          frame_d  = 2'd0;
          byte_d   = 3'd0;
          addr_d   = reg_addr;
          data_d   = reg_data;
          busy_d   = 1'b1;
        end
      end
      ST_SEND: begin
        sel_byte = byte_q + 3'd1;
        if (tx_ready) begin
          if (byte_q != LAST_BYTE) begin
            tx_valid = 1'b1;
            byte_d   = byte_q + 3'd1;
          end else if (frame_q != LAST_FRAME) begin
            state_d = ST_GAP;
            frame_d = frame_q + 2'd1;
            byte_d  = 3'd0;
            gap_d   = 16'd0;
          end else begin
            state_d = ST_DONE;
            frame_d = 2'd0;
            byte_d  = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          tx_valid = 1'b1;
          state_d  = ST_SEND;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= 2'd0;
      byte_q  <= 3'd0;
      gap_q   <= 16'd0;
      addr_q  <= 8'h00;
      data_q  <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
